// File: rtl/fifo_oe_pkg.sv
// -----------------------------------------------------------------------------
// fifo_oe_pkg
// Shared definitions for the odd/even FIFO-pair controller.
//   state_t        : 2-bit controller state encoding (IDLE/RUN/DRAIN/FLUSH)
//   DEPTH_DEF      : default entries per FIFO
//   LEN_W_DEF      : default job-length width (64-bit words)
//   occ_width()    : occupancy counter width for a given FIFO depth
// -----------------------------------------------------------------------------
package fifo_oe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam int DEPTH_DEF = 16;
    localparam int LEN_W_DEF = 16;

    // One extra bit so that a completely full FIFO (occ == DEPTH) is representable.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_oe_occ.sv
// -----------------------------------------------------------------------------
// fifo_oe_occ
// Occupancy mirror for one FIFO of the odd/even pair.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : synchronous clear (flush of the pair)
//   inc      : entries written this cycle (0, 1 or 2)
//   dec      : entry read this cycle (0 or 1)
//   occ      : current entry count, 0..DEPTH
// A write and a read in the same cycle are applied as one net update, so the
// count never passes through a transient full or empty value.
// -----------------------------------------------------------------------------
module fifo_oe_occ
    import fifo_oe_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int OCC_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [1:0]       inc,
    input  logic             dec,
    output logic [OCC_W-1:0] occ
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            occ <= '0;
        end else begin
            occ <= occ + OCC_W'(inc) - OCC_W'(dec);
        end
    end

`ifndef SYNTHESIS
    // The controller must never let the mirror underflow or exceed DEPTH.
    always_ff @(posedge clk) begin
        if (!rst && !clear) begin
            assert (int'(occ) + int'(inc) >= int'(dec))
                else $error("fifo_oe_occ: occupancy underflow (occ=%0d dec=%0d)", occ, dec);
            assert (int'(occ) + int'(inc) - int'(dec) <= DEPTH)
                else $error("fifo_oe_occ: occupancy overflow (occ=%0d inc=%0d)", occ, inc);
        end
    end
`endif

endmodule

// File: rtl/fifo_oe_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_oe_ctrl
// Job sequencer and flow controller for the odd/even FIFO pair. Accepts a job
// (length in 64-bit words, 1- or 2-entry beats), steers producer beats
// alternately to the even (fifo0) and odd (fifo1) FIFO, mirrors each FIFO's
// occupancy for backpressure and paces consumer reads until the job ends.
// Owns no data storage; drives only wen/ren/w2entry/flush of the pair.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_start/len/w2entry/abort   job control (start accepted only in IDLE)
//   in_valid, in_ready  producer beat handshake
//   fifo_w2entry        per-job copy of cfg_w2entry
//   fifo0_wen/fifo1_wen write strobes, even/odd FIFO
//   fifo_empty          combined empty of the pair
//   out_ready/out_valid consumer handshake, fifo_ren = read strobe
//   fifo_flush          1-cycle pulse clearing the pair
//   busy, done, cfg_err status (done/cfg_err are 1-cycle pulses)
//   stat_in_stall/stat_out_stall  stall counters, only with FIFO_OE_STAT_EN
//   dbg_state, dbg_occ0, dbg_occ1 controller state and occupancy mirrors
//
// Handshakes: a transfer happens in exactly the cycle where valid and ready
// are both high; valid never depends on ready (in_ready and out_valid are
// functions of registered state and fifo_empty only).
//
// Optional feature macro: FIFO_OE_STAT_EN (stall statistics outputs).
// -----------------------------------------------------------------------------
module fifo_oe_ctrl
    import fifo_oe_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int LEN_W = LEN_W_DEF,
    localparam int OCC_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_w2entry,
    input  logic             cfg_abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             fifo_w2entry,
    output logic             fifo0_wen,
    output logic             fifo1_wen,
    input  logic             fifo_empty,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             fifo_ren,
    output logic             fifo_flush,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
`ifdef FIFO_OE_STAT_EN
    output logic [15:0]      stat_in_stall,
    output logic [15:0]      stat_out_stall,
`endif
    output state_t           dbg_state,
    output logic [OCC_W-1:0] dbg_occ0,
    output logic [OCC_W-1:0] dbg_occ1
);

    state_t           state;
    logic [LEN_W-1:0] job_len;
    logic [LEN_W-1:0] wr_cnt;
    logic [LEN_W-1:0] rd_cnt;
    logic             w2;
    logic             wr_par;
    logic             rd_par;
    logic [OCC_W-1:0] occ0;
    logic [OCC_W-1:0] occ1;

    logic             run;
    logic             active;
    logic [OCC_W-1:0] occ_wr;
    logic [OCC_W-1:0] room_lim;
    logic             accept;
    logic [LEN_W-1:0] n_words;
    logic             last_wr;
    logic             last_rd;
    logic             rd_all;
    logic             start_bad;
    logic [1:0]       inc0;
    logic [1:0]       inc1;
    logic             dec0;
    logic             dec1;

    assign run    = (state == ST_RUN);
    assign active = run || (state == ST_DRAIN);

    // Beat goes to the FIFO selected by wr_par; it fits if n more entries fit.
    assign occ_wr   = wr_par ? occ1 : occ0;
    assign room_lim = w2 ? OCC_W'(DEPTH - 2) : OCC_W'(DEPTH - 1);
    assign in_ready = run && (occ_wr <= room_lim);
    assign accept   = in_valid && in_ready;

    assign fifo0_wen    = accept && !wr_par;
    assign fifo1_wen    = accept &&  wr_par;
    assign fifo_w2entry = w2;

    assign out_valid = active && !fifo_empty && (rd_cnt < job_len);
    assign fifo_ren  = out_valid && out_ready;

    assign n_words = w2 ? LEN_W'(2) : LEN_W'(1);
    assign last_wr = accept && ((wr_cnt + n_words) == job_len);
    assign last_rd = fifo_ren && ((rd_cnt + LEN_W'(1)) == job_len);
    assign rd_all  = (rd_cnt == job_len);

    // A 2-entry job must be an even number of words.
    assign start_bad = (cfg_len == '0) || (cfg_w2entry && cfg_len[0]);

    assign inc0 = fifo0_wen ? (w2 ? 2'd2 : 2'd1) : 2'd0;
    assign inc1 = fifo1_wen ? (w2 ? 2'd2 : 2'd1) : 2'd0;
    // rd_par follows the pair's internal read select.
    assign dec0 = fifo_ren && !rd_par;
    assign dec1 = fifo_ren &&  rd_par;

    assign fifo_flush = (state == ST_FLUSH);
    assign busy       = (state != ST_IDLE);
    assign dbg_state  = state;
    assign dbg_occ0   = occ0;
    assign dbg_occ1   = occ1;

    fifo_oe_occ #(.DEPTH(DEPTH)) u_occ0 (
        .clk   (clk),
        .rst   (rst),
        .clear (fifo_flush),
        .inc   (inc0),
        .dec   (dec0),
        .occ   (occ0)
    );

    fifo_oe_occ #(.DEPTH(DEPTH)) u_occ1 (
        .clk   (clk),
        .rst   (rst),
        .clear (fifo_flush),
        .inc   (inc1),
        .dec   (dec1),
        .occ   (occ1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            job_len <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            w2      <= 1'b0;
            wr_par  <= 1'b0;
            rd_par  <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;

            // Job counters; only move in RUN/DRAIN where handshakes can occur.
            if (accept) begin
                wr_cnt <= wr_cnt + n_words;
                wr_par <= !wr_par;
            end
            if (fifo_ren) begin
                rd_cnt <= rd_cnt + LEN_W'(1);
                rd_par <= !rd_par;
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        if (start_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            job_len <= cfg_len;
                            w2      <= cfg_w2entry;
                            wr_cnt  <= '0;
                            rd_cnt  <= '0;
                            wr_par  <= 1'b0;
                            rd_par  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (cfg_abort) begin
                        state <= ST_FLUSH;
                    end else if (last_wr) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Abort has priority over the final read: no done then.
                    if (cfg_abort) begin
                        state <= ST_FLUSH;
                    end else if (last_rd || rd_all) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state  <= ST_IDLE;
                    wr_par <= 1'b0;
                    rd_par <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIFO_OE_STAT_EN
    // Saturating stall counters, restarted by every accepted job start.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && cfg_start && !start_bad)) begin
            stat_in_stall  <= '0;
            stat_out_stall <= '0;
        end else begin
            if (in_valid && !in_ready && stat_in_stall != 16'hFFFF) begin
                stat_in_stall <= stat_in_stall + 16'd1;
            end
            if (busy && out_ready && !out_valid && stat_out_stall != 16'hFFFF) begin
                stat_out_stall <= stat_out_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_oe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_oe_ctrl
// Drives jobs into fifo_oe_ctrl and models the odd/even FIFO pair around it.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. The pair model holds producer words; every word read is
// compared against the job's word order held in exp_q.
// -----------------------------------------------------------------------------
module tb_fifo_oe_ctrl;
    import fifo_oe_pkg::*;

    localparam int DEPTH = 16;
    localparam int LEN_W = 16;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             cfg_start = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_w2entry = 1'b0;
    logic             cfg_abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             fifo_w2entry;
    logic             fifo0_wen;
    logic             fifo1_wen;
    logic             fifo_empty = 1'b1;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic             fifo_ren;
    logic             fifo_flush;
    logic             busy;
    logic             done;
    logic             cfg_err;
    state_t           dbg_state;
    logic [OCC_W-1:0] dbg_occ0;
    logic [OCC_W-1:0] dbg_occ1;

    fifo_oe_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_len      (cfg_len),
        .cfg_w2entry  (cfg_w2entry),
        .cfg_abort    (cfg_abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fifo_w2entry (fifo_w2entry),
        .fifo0_wen    (fifo0_wen),
        .fifo1_wen    (fifo1_wen),
        .fifo_empty   (fifo_empty),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .fifo_ren     (fifo_ren),
        .fifo_flush   (fifo_flush),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .dbg_state    (dbg_state),
        .dbg_occ0     (dbg_occ0),
        .dbg_occ1     (dbg_occ1)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic        m_rd_par = 1'b0;

    logic [63:0] in_lo = '0;
    logic [63:0] in_hi = '0;

    int job_no = 0;
    int job_len = 0;
    bit job_w2 = 1'b0;
    int beat_idx = 0;
    int rd_seen = 0;
    int done_cnt = 0;
    int done_base = 0;
    bit exp_done = 1'b0;
    bit rr_stop = 1'b0;

    logic        pend_w0 = 1'b0;
    logic        pend_w1 = 1'b0;
    logic        pend_ren = 1'b0;
    logic        pend_flush = 1'b0;
    logic        pend_w2 = 1'b0;
    logic [63:0] pend_lo = '0;
    logic [63:0] pend_hi = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] word_of(input int j, input int idx);
        return {32'(j), 32'(idx)};
    endfunction

    // ---------------- FIFO pair model: applies last cycle's strobes ----------------
    always @(posedge clk) begin
        if (rst || pend_flush) begin
            q0.delete();
            q1.delete();
            m_rd_par = 1'b0;
        end else begin
            if (pend_ren) begin
                if (m_rd_par) begin
                    if (q1.size() != 0) void'(q1.pop_front());
                end else begin
                    if (q0.size() != 0) void'(q0.pop_front());
                end
                m_rd_par = !m_rd_par;
            end
            if (pend_w0) begin
                q0.push_back(pend_lo);
                if (pend_w2) q0.push_back(pend_hi);
            end
            if (pend_w1) begin
                q1.push_back(pend_lo);
                if (pend_w2) q1.push_back(pend_hi);
            end
        end
        fifo_empty <= m_rd_par ? (q1.size() == 0) : (q0.size() == 0);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [63:0] got_w;
        logic [63:0] exp_w;
        pend_w0    = fifo0_wen;
        pend_w1    = fifo1_wen;
        pend_ren   = fifo_ren;
        pend_flush = fifo_flush;
        pend_w2    = fifo_w2entry;
        pend_lo    = in_lo;
        pend_hi    = in_hi;
        if (!rst) begin
            if (fifo0_wen && fifo1_wen) check_eq("wen_both", 64'd1, 64'd0);
            if (fifo_ren) begin
                if (m_rd_par) got_w = (q1.size() != 0) ? q1[0] : '1;
                else          got_w = (q0.size() != 0) ? q0[0] : '1;
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                check_eq("rd_data", got_w, exp_w);
            end
            if (done || exp_done) check_eq("done_pulse", 64'(done), 64'(exp_done));
            exp_done = fifo_ren && !cfg_abort && (rd_seen + 1 == job_len);
            if (fifo_ren) rd_seen++;
            if (done) done_cnt++;
        end
    end

    // ---------------- driver tasks (called at posedge+1, return at posedge+1) ----------------
    task automatic start_job(input int len, input bit w2);
        int p;
        int o;
        job_no++;
        job_len   = len;
        job_w2    = w2;
        beat_idx  = 0;
        rd_seen   = 0;
        done_base = done_cnt;
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(word_of(job_no, i));
        cfg_start   = 1'b1;
        cfg_len     = LEN_W'(len);
        cfg_w2entry = w2;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        check_eq("start_state", 64'(dbg_state), 64'(ST_RUN));
        @(posedge clk); #1;
    endtask

    task automatic present_beat();
        int p;
        int o;
        in_valid = 1'b1;
        if (!job_w2) begin
            in_lo = word_of(job_no, beat_idx);
            in_hi = '0;
        end else begin
            // Pre-interleave so that alternating reads return words in order.
            p = beat_idx / 2;
            o = beat_idx % 2;
            in_lo = word_of(job_no, 4 * p + o);
            in_hi = word_of(job_no, 4 * p + o + 2);
        end
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        beat_idx++;
        if (!ok) check_eq("beat_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_beats(input int count);
        for (int i = 0; i < count; i++) begin
            present_beat();
            wait_accept();
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == done_base && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("done_count", 64'(done_cnt), 64'(done_base + 1));
        @(negedge clk);
        check_eq("end_state", 64'(dbg_state), 64'(ST_IDLE));
        check_eq("end_busy", 64'(busy), 64'd0);
        check_eq("end_expq", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic bad_start(input int len, input bit w2, input logic exp_err, input state_t exp_st);
        cfg_start   = 1'b1;
        cfg_len     = LEN_W'(len);
        cfg_w2entry = w2;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        check_eq("cfg_err", 64'(cfg_err), 64'(exp_err));
        check_eq("bad_start_state", 64'(dbg_state), 64'(exp_st));
        @(negedge clk);
        check_eq("cfg_err_clear", 64'(cfg_err), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    typedef struct { int len; bit w2; } rjob_t;
    rjob_t rjobs[3] = '{'{20, 1'b1}, '{12, 1'b0}, '{16, 1'b1}};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_flags", 64'({done, cfg_err, fifo_flush, fifo_w2entry}), 64'd0);
        check_eq("rst_occ", 64'({dbg_occ0, dbg_occ1}), 64'd0);
        @(posedge clk); #1;

        // 1: len 8, single entry, consumer always ready
        out_ready = 1'b1;
        start_job(8, 1'b0);
        send_beats(8);
        wait_done();

        // 2: len 8, two entries per beat, reads held off to see the peak
        out_ready = 1'b0;
        start_job(8, 1'b1);
        send_beats(4);
        @(negedge clk);
        check_eq("t2_occ0", 64'(dbg_occ0), 64'd4);
        check_eq("t2_occ1", 64'(dbg_occ1), 64'd4);
        check_eq("t2_w2entry", 64'(fifo_w2entry), 64'd1);
        check_eq("t2_state", 64'(dbg_state), 64'(ST_DRAIN));
        @(posedge clk); #1;
        bad_start(0, 1'b0, 1'b0, ST_DRAIN);  // start while busy: ignored, no error
        out_ready = 1'b1;
        wait_done();

        // 3: len 64, consumer stalled -> backpressure at 16/16
        out_ready = 1'b0;
        start_job(64, 1'b0);
        send_beats(32);
        present_beat();
        repeat (3) @(negedge clk);
        check_eq("t3_in_ready", 64'(in_ready), 64'd0);
        check_eq("t3_occ0", 64'(dbg_occ0), 64'(DEPTH));
        check_eq("t3_occ1", 64'(dbg_occ1), 64'(DEPTH));
        check_eq("t3_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept();
        send_beats(31);
        wait_done();

        // 4: write and read of the same FIFO at occ = DEPTH-1
        out_ready = 1'b0;
        start_job(34, 1'b0);
        send_beats(31);                       // occ0=16, occ1=15, next write -> fifo1
        out_ready = 1'b1;                     // one read from fifo0, read select -> fifo1
        @(negedge clk);
        check_eq("t4_first_ren", 64'(fifo_ren), 64'd1);
        @(posedge clk); #1;
        present_beat();
        @(negedge clk);
        check_eq("t4_in_ready", 64'(in_ready), 64'd1);
        check_eq("t4_same_fifo", 64'({fifo1_wen, fifo_ren}), 64'd3);
        check_eq("t4_occ1_before", 64'(dbg_occ1), 64'(DEPTH - 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        beat_idx++;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("t4_occ1_after", 64'(dbg_occ1), 64'(DEPTH - 1));
        check_eq("t4_occ0_after", 64'(dbg_occ0), 64'(DEPTH - 1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_beats(2);
        wait_done();

        // 5: abort in RUN with 5 entries per FIFO, then a fresh job
        out_ready = 1'b0;
        start_job(16, 1'b0);
        send_beats(10);
        @(negedge clk);
        check_eq("t5_occ0", 64'(dbg_occ0), 64'd5);
        check_eq("t5_occ1", 64'(dbg_occ1), 64'd5);
        @(posedge clk); #1;
        cfg_abort = 1'b1;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("t5_flush", 64'(fifo_flush), 64'd1);
        check_eq("t5_flush_state", 64'(dbg_state), 64'(ST_FLUSH));
        @(negedge clk);
        check_eq("t5_flush_end", 64'(fifo_flush), 64'd0);
        check_eq("t5_idle", 64'(dbg_state), 64'(ST_IDLE));
        check_eq("t5_occ_clr", 64'({dbg_occ0, dbg_occ1}), 64'd0);
        check_eq("t5_no_done", 64'(done_cnt), 64'(done_base));
        @(posedge clk); #1;
        out_ready = 1'b1;
        start_job(4, 1'b0);
        send_beats(4);
        wait_done();

        // 6: illegal starts
        bad_start(3, 1'b1, 1'b1, ST_IDLE);
        bad_start(0, 1'b0, 1'b1, ST_IDLE);

        // Random consumer pacing
        foreach (rjobs[k]) begin
            rr_stop = 1'b0;
            fork
                begin
                    while (!rr_stop) begin
                        out_ready = 1'($urandom_range(0, 1));
                        @(posedge clk); #1;
                    end
                end
            join_none
            start_job(rjobs[k].len, rjobs[k].w2);
            send_beats(rjobs[k].w2 ? rjobs[k].len / 2 : rjobs[k].len);
            wait_done();
            rr_stop = 1'b1;
            @(posedge clk); #2;
            out_ready = 1'b0;
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #900000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
